// File: rtl/seven_seg_scanner.sv
// Captures packed BCD from the binary-to-BCD converter and time-multiplexes it onto a
// 4-digit common-anode 7-segment display with blanking, leading-zero suppression and dp.
module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV    = 1000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter bit          ACTIVE_LOW_SEG = 1'b1,
   parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_in,
   input  logic        bcd_ready,
   input  logic        enable,
   input  logic        blank_lz,
   input  logic [3:0]  dp_mask,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx,
   output logic        bcd_err
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST     = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_SHOW_END = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
   localparam bit            HAS_BLANK    = (BLANK_CYCLES != 0);

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   function automatic logic bad_bcd(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
         else                    bad = bad;
      end
      return bad;
   endfunction

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    dig_r, dig_s;
   logic          wrap_s, xfer_ok_s, cap_s, rdy_d_r;
   logic [15:0]   shadow_r, shadow_s, disp_r, disp_s;
   logic          pending_r, pending_s, err_r;
   logic [3:0]    nib_s, an_s, an_r;
   logic [6:0]    seg_s, seg_r;
   logic          dp_s, dp_r, lz_blank_s;

   assign cap_s     = bcd_ready & ~rdy_d_r;
   assign xfer_ok_s = (state_r == IDLE) | wrap_s;

   // Slot sequencing: next state, slot counter and digit index.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      dig_s   = dig_r;
      wrap_s  = 1'b0;
      if (!enable) begin
         state_s = IDLE;
         cnt_s   = '0;
         dig_s   = 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = SHOW;
               cnt_s   = '0;
               dig_s   = 2'd0;
            end
            SHOW: begin
               if (!HAS_BLANK && cnt_r == CNT_LAST) begin
                  cnt_s  = '0;
                  dig_s  = dig_r + 2'd1;
                  wrap_s = (dig_r == 2'd3);
               end else if (HAS_BLANK && cnt_r == CNT_SHOW_END) begin
                  state_s = BLANK;
                  cnt_s   = cnt_r + 1'b1;
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            BLANK: begin
               if (cnt_r == CNT_LAST) begin
                  state_s = SHOW;
                  cnt_s   = '0;
                  dig_s   = dig_r + 2'd1;
                  wrap_s  = (dig_r == 2'd3);
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = '0;
               dig_s   = 2'd0;
            end
         endcase
      end
   end

   // Capture and tear-free transfer: disp only changes while idle or on the frame wrap.
   always_comb begin
      shadow_s  = shadow_r;
      disp_s    = disp_r;
      pending_s = pending_r;
      if (cap_s) begin
         shadow_s = bcd_in;
         if (xfer_ok_s) begin
            disp_s    = bcd_in;
            pending_s = 1'b0;
         end else begin
            pending_s = 1'b1;
         end
      end else if (pending_r && xfer_ok_s) begin
         disp_s    = shadow_r;
         pending_s = 1'b0;
      end else begin
         pending_s = pending_r;
      end
   end

   // Output pattern for the upcoming cycle, taken from next state and next display value.
   always_comb begin
      nib_s = disp_s[{dig_s, 2'b00} +: 4];
      case (dig_s)
         2'd1:    lz_blank_s = blank_lz && (disp_s[15:4] == 12'h000);
         2'd2:    lz_blank_s = blank_lz && (disp_s[15:8] == 8'h00);
         2'd3:    lz_blank_s = blank_lz && (disp_s[15:12] == 4'h0);
         default: lz_blank_s = 1'b0;
      endcase
      if (state_s == SHOW) begin
         an_s  = 4'b0001 << dig_s;
         seg_s = lz_blank_s ? 7'h00 : seg_decode(nib_s);
         dp_s  = dp_mask[dig_s];
      end else begin
         an_s  = 4'b0000;
         seg_s = 7'h00;
         dp_s  = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         dig_r   <= 2'd0;
         rdy_d_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         dig_r   <= dig_s;
         rdy_d_r <= bcd_ready;
      end
   end

   // Data registers; error flag is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_r  <= 16'h0000;
         disp_r    <= 16'h0000;
         pending_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         shadow_r  <= shadow_s;
         disp_r    <= disp_s;
         pending_r <= pending_s;
         err_r     <= err_r | (cap_s & bad_bcd(bcd_in));
      end
   end

   // Registered, polarity-adjusted display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= {4{ACTIVE_LOW_AN}};
         seg_r <= {7{ACTIVE_LOW_SEG}};
         dp_r  <= ACTIVE_LOW_SEG;
      end else begin
         an_r  <= an_s ^ {4{ACTIVE_LOW_AN}};
         seg_r <= seg_s ^ {7{ACTIVE_LOW_SEG}};
         dp_r  <= dp_s ^ ACTIVE_LOW_SEG;
      end
   end

   assign an        = an_r;
   assign seg       = seg_r;
   assign dp        = dp_r;
   assign digit_idx = dig_r;
   assign bcd_err   = err_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (REFRESH_DIV=8, BLANK_CYCLES=2, active-low).
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in = 16'h0000;
   logic        bcd_ready = 1'b0;
   logic        enable = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  dp_mask = 4'h0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        bcd_err;

   int n_cmp = 0;
   int n_bad = 0;

   seven_seg_scanner #(
      .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_ready(bcd_ready), .enable(enable),
      .blank_lz(blank_lz), .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an),
      .digit_idx(digit_idx), .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; bcd_ready = 1'b0; enable = 1'b0; blank_lz = 1'b0;
      dp_mask = 4'h0; bcd_in = 16'h0000;
      run(2);
      rst = 1'b0;
      run(1);
   endtask

   task automatic pulse_ready(input logic [15:0] v);
      bcd_in = v;
      bcd_ready = 1'b1;
      run(1);
      bcd_ready = 1'b0;
   endtask

   // 1: reset state, and async reset asserted in the middle of a SHOW slot
   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({an, seg, dp, digit_idx, bcd_err} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_idle: got an=%h seg=%h dp=%b idx=%0d err=%b want an=F seg=7F dp=1 idx=0 err=0",
                  an, seg, dp, digit_idx, bcd_err);
      end
      pulse_ready(16'h00A5);
      run(1);
      enable = 1'b1; dp_mask = 4'b0001;
      run(3);
      n_cmp++;
      if ({an, seg, dp, bcd_err} !== {4'hE, 7'h12, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL pre_reset_show: got an=%h seg=%h dp=%b err=%b want an=E seg=12 dp=0 err=1",
                  an, seg, dp, bcd_err);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({an, seg, dp, digit_idx, bcd_err} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid_show: got an=%h seg=%h dp=%b idx=%0d err=%b want an=F seg=7F dp=1 idx=0 err=0",
                  an, seg, dp, digit_idx, bcd_err);
      end
      run(1);
      rst = 1'b0; enable = 1'b0; dp_mask = 4'h0;
      run(1);
   endtask

   // 2: capture while scanning, value appears from digit 0 after the wrap; slot timing
   task automatic test_capture();
      do_reset();
      enable = 1'b1;
      run(1);
      n_cmp++;
      if ({an, seg, digit_idx} !== {4'hE, 7'h40, 2'd0}) begin
         n_bad++;
         $display("FAIL first_show: got an=%h seg=%h idx=%0d want an=E seg=40 idx=0", an, seg, digit_idx);
      end
      run(8);
      pulse_ready(16'h1234);
      n_cmp++;
      if ({an, seg} !== {4'hD, 7'h40}) begin
         n_bad++;
         $display("FAIL cap_d1_old: got an=%h seg=%h want an=D seg=40", an, seg);
      end
      run(7);
      n_cmp++;
      if ({an, seg} !== {4'hB, 7'h40}) begin
         n_bad++;
         $display("FAIL cap_d2_old: got an=%h seg=%h want an=B seg=40", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'h7, 7'h40}) begin
         n_bad++;
         $display("FAIL cap_d3_old: got an=%h seg=%h want an=7 seg=40", an, seg);
      end
      run(8);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({an, seg, digit_idx} !== {4'hE, 7'h19, 2'd0}) begin
            n_bad++;
            $display("FAIL d0_show[%0d]: got an=%h seg=%h idx=%0d want an=E seg=19 idx=0", i, an, seg, digit_idx);
         end
         run(1);
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({an, seg} !== {4'hF, 7'h7F}) begin
            n_bad++;
            $display("FAIL d0_blank[%0d]: got an=%h seg=%h want an=F seg=7F", i, an, seg);
         end
         run(1);
      end
      n_cmp++;
      if ({an, seg, digit_idx} !== {4'hD, 7'h30, 2'd1}) begin
         n_bad++;
         $display("FAIL d1_show: got an=%h seg=%h idx=%0d want an=D seg=30 idx=1", an, seg, digit_idx);
      end
   endtask

   // 4: new value captured on digit 1 must not produce a mixed frame (continues from test_capture)
   task automatic test_back_to_back();
      pulse_ready(16'h9999);
      n_cmp++;
      if ({an, seg} !== {4'hD, 7'h30}) begin
         n_bad++;
         $display("FAIL tear_d1: got an=%h seg=%h want an=D seg=30", an, seg);
      end
      run(7);
      n_cmp++;
      if ({an, seg} !== {4'hB, 7'h24}) begin
         n_bad++;
         $display("FAIL tear_d2: got an=%h seg=%h want an=B seg=24", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'h7, 7'h79}) begin
         n_bad++;
         $display("FAIL tear_d3: got an=%h seg=%h want an=7 seg=79", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'hE, 7'h10}) begin
         n_bad++;
         $display("FAIL new_d0: got an=%h seg=%h want an=E seg=10", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'hD, 7'h10}) begin
         n_bad++;
         $display("FAIL new_d1: got an=%h seg=%h want an=D seg=10", an, seg);
      end
   endtask

   // 3: leading-zero suppression and live dp mask
   task automatic test_leading_zero();
      do_reset();
      blank_lz = 1'b1;
      pulse_ready(16'h0042);
      run(2);
      enable = 1'b1;
      run(1);
      n_cmp++;
      if ({an, seg} !== {4'hE, 7'h24}) begin
         n_bad++;
         $display("FAIL lz_d0: got an=%h seg=%h want an=E seg=24", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'hD, 7'h19}) begin
         n_bad++;
         $display("FAIL lz_d1: got an=%h seg=%h want an=D seg=19", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg, dp} !== {4'hB, 7'h7F, 1'b1}) begin
         n_bad++;
         $display("FAIL lz_d2: got an=%h seg=%h dp=%b want an=B seg=7F dp=1", an, seg, dp);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'h7, 7'h7F}) begin
         n_bad++;
         $display("FAIL lz_d3: got an=%h seg=%h want an=7 seg=7F", an, seg);
      end
      dp_mask = 4'b1000;
      run(1);
      n_cmp++;
      if ({an, seg, dp} !== {4'h7, 7'h7F, 1'b0}) begin
         n_bad++;
         $display("FAIL lz_d3_dp: got an=%h seg=%h dp=%b want an=7 seg=7F dp=0", an, seg, dp);
      end
      blank_lz = 1'b0;
      run(1);
      n_cmp++;
      if ({an, seg, dp} !== {4'h7, 7'h40, 1'b0}) begin
         n_bad++;
         $display("FAIL nolz_d3: got an=%h seg=%h dp=%b want an=7 seg=40 dp=0", an, seg, dp);
      end
   endtask

   // 5: invalid nibble sets sticky error and decodes as dash
   task automatic test_bcd_err();
      do_reset();
      n_cmp++;
      if (bcd_err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: got err=%b want err=0", bcd_err);
      end
      pulse_ready(16'h00A5);
      n_cmp++;
      if (bcd_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_set: got err=%b want err=1", bcd_err);
      end
      run(1);
      enable = 1'b1;
      run(1);
      n_cmp++;
      if ({an, seg} !== {4'hE, 7'h12}) begin
         n_bad++;
         $display("FAIL err_d0: got an=%h seg=%h want an=E seg=12", an, seg);
      end
      run(8);
      n_cmp++;
      if ({an, seg} !== {4'hD, 7'h3F}) begin
         n_bad++;
         $display("FAIL err_d1_dash: got an=%h seg=%h want an=D seg=3F", an, seg);
      end
      pulse_ready(16'h0001);
      run(1);
      n_cmp++;
      if (bcd_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky: got err=%b want err=1", bcd_err);
      end
      run(22);
      n_cmp++;
      if ({an, seg, bcd_err} !== {4'hE, 7'h79, 1'b1}) begin
         n_bad++;
         $display("FAIL err_new_d0: got an=%h seg=%h err=%b want an=E seg=79 err=1", an, seg, bcd_err);
      end
   endtask

   // 6: enable dropped mid-SHOW, then restart from digit 0 with counter cleared
   task automatic test_abort();
      do_reset();
      bcd_in = 16'h0000;
      enable = 1'b1;
      run(19);
      n_cmp++;
      if ({an, digit_idx} !== {4'hB, 2'd2}) begin
         n_bad++;
         $display("FAIL abort_pre: got an=%h idx=%0d want an=B idx=2", an, digit_idx);
      end
      enable = 1'b0;
      run(1);
      n_cmp++;
      if ({an, seg, digit_idx} !== {4'hF, 7'h7F, 2'd0}) begin
         n_bad++;
         $display("FAIL abort_idle: got an=%h seg=%h idx=%0d want an=F seg=7F idx=0", an, seg, digit_idx);
      end
      run(3);
      n_cmp++;
      if (an !== 4'hF) begin
         n_bad++;
         $display("FAIL abort_stay: got an=%h want an=F", an);
      end
      enable = 1'b1;
      run(1);
      n_cmp++;
      if ({an, digit_idx} !== {4'hE, 2'd0}) begin
         n_bad++;
         $display("FAIL restart_d0: got an=%h idx=%0d want an=E idx=0", an, digit_idx);
      end
      run(5);
      n_cmp++;
      if (an !== 4'hE) begin
         n_bad++;
         $display("FAIL restart_cnt5: got an=%h want an=E", an);
      end
      run(1);
      n_cmp++;
      if (an !== 4'hF) begin
         n_bad++;
         $display("FAIL restart_blank: got an=%h want an=F", an);
      end
      run(2);
      n_cmp++;
      if ({an, digit_idx} !== {4'hD, 2'd1}) begin
         n_bad++;
         $display("FAIL restart_d1: got an=%h idx=%0d want an=D idx=1", an, digit_idx);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_back_to_back();
      test_leading_zero();
      test_bcd_err();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
